data_mem_resp: RTL and testbench

Memory responder for the pipelined processor: serves the fetch port (InstrAddr → InstrMem) and the data port (MemAddr/MemRead/MemWrite/WriteL/WriteR/WriteData → MemData) from one dual-port word array. Before the core runs, an external loader fills the array through a valid/ready stream; the block holds the processor in reset until loading completes. Sits beside PROCESSOR at top level; processor drives nReset of the core via ProcnReset.

---
 rtl/data_mem_resp.sv | 135 +++++++++++++
 tb/tb_data_mem_resp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// Dual-port word memory serving processor fetch and data ports, preloaded over a
// valid/ready stream while the processor core is held in reset.
//
// state | meaning
// BOOT  | loader owns the array, core held in reset, processor ports ignored
// RUN   | processor owns the array, loader ignored, core released
module data_mem_resp #(
  parameter int DEPTH = 1024
) (
  input  logic                       Clock,
  input  logic                       nReset,
  input  logic [15:0]                InstrAddr,
  output logic [31:0]                InstrMem,
  input  logic [15:0]                MemAddr,
  input  logic                       MemRead,
  input  logic                       MemWrite,
  input  logic                       WriteL,
  input  logic                       WriteR,
  input  logic [31:0]                WriteData,
  output logic [31:0]                MemData,
  input  logic                       LoadValid,
  output logic                       LoadReady,
  input  logic [$clog2(DEPTH)-1:0]   LoadAddr,
  input  logic [31:0]                LoadData,
  input  logic                       LoadLast,
  output logic                       ProcnReset,
  output logic                       Err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t        state_q, state_next;
  logic          load_ready_q, proc_rst_q, err_q;
  logic          load_fire, proc_write, bad_write;
  logic [AW-1:0] instr_idx, mem_idx;
  logic [3:0]    lane_be;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;
  logic [31:0]   mem [DEPTH];
  logic          unused_addr;

  assign instr_idx = InstrAddr[AW+1:2];
  assign mem_idx   = MemAddr[AW+1:2];
  // Bits outside the word index are ignored: upper bits alias, fetch lane is don't-care.
  assign unused_addr = ^{InstrAddr >> (AW + 2), InstrAddr[1:0], MemAddr >> (AW + 2)};

  assign load_fire  = LoadValid & load_ready_q & (state_q == BOOT);
  assign bad_write  = MemWrite & WriteL & WriteR;
  assign proc_write = (state_q == RUN) & MemWrite & ~(WriteL & WriteR);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state_q <= BOOT;
    else         state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      BOOT:    if (load_fire && LoadLast) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // Ready tracks the upcoming state so no beat is offered once RUN is entered.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      load_ready_q <= 1'b0;
      proc_rst_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      load_ready_q <= (state_next == BOOT);
      proc_rst_q   <= (state_q == RUN);
      if ((state_q == RUN) && bad_write) err_q <= 1'b1;
    end
  end

  assign LoadReady  = load_ready_q;
  assign ProcnReset = proc_rst_q;
  assign Err        = err_q;

  // Little-endian lanes: SWL covers lanes 0..lane, SWR covers lane..3.
  always_comb begin
    lane_be = 4'b1111;
    if (WriteL) begin
      case (MemAddr[1:0])
        2'd0:    lane_be = 4'b0001;
        2'd1:    lane_be = 4'b0011;
        2'd2:    lane_be = 4'b0111;
        default: lane_be = 4'b1111;
      endcase
    end else if (WriteR) begin
      lane_be = 4'b1111 << MemAddr[1:0];
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = mem_idx;
    wr_data = WriteData;
    wr_be   = lane_be;
    if (load_fire) begin
      wr_en   = 1'b1;
      wr_idx  = LoadAddr;
      wr_data = LoadData;
      wr_be   = 4'b1111;
    end else if (proc_write) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  // Reads sample the array before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      InstrMem <= 32'h0;
      MemData  <= 32'h0;
    end else if (state_q == RUN) begin
      InstrMem <= mem[instr_idx];
      if (MemRead) MemData <= mem[mem_idx];
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: boot load, fetch, word/partial stores,
// read-first behaviour, aliasing and reset in RUN, checked through a scoreboard.
module tb_data_mem_resp;

  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  logic          Clock = 1'b0;
  logic          nReset;
  logic [15:0]   InstrAddr;
  logic [31:0]   InstrMem;
  logic [15:0]   MemAddr;
  logic          MemRead, MemWrite, WriteL, WriteR;
  logic [31:0]   WriteData;
  logic [31:0]   MemData;
  logic          LoadValid;
  logic          LoadReady;
  logic [AW-1:0] LoadAddr;
  logic [31:0]   LoadData;
  logic          LoadLast;
  logic          ProcnReset;
  logic          Err;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    string       tag;
    bit          instr;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  data_mem_resp #(.DEPTH(DEPTH)) dut (
    .Clock(Clock), .nReset(nReset),
    .InstrAddr(InstrAddr), .InstrMem(InstrMem),
    .MemAddr(MemAddr), .MemRead(MemRead), .MemWrite(MemWrite),
    .WriteL(WriteL), .WriteR(WriteR), .WriteData(WriteData), .MemData(MemData),
    .LoadValid(LoadValid), .LoadReady(LoadReady), .LoadAddr(LoadAddr),
    .LoadData(LoadData), .LoadLast(LoadLast),
    .ProcnReset(ProcnReset), .Err(Err)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_instr(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.instr = 1'b1; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic expect_data(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.instr = 1'b0; e.exp = exp;
    sb.push_back(e);
  endtask

  // Every scoreboard entry expects its result one edge after it was pushed.
  task automatic step();
    exp_t e;
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, e.instr ? InstrMem : MemData, e.exp);
    end
  endtask

  task automatic proc_idle();
    MemRead = 0; MemWrite = 0; WriteL = 0; WriteR = 0;
  endtask

  task automatic store(input logic [15:0] a, input logic [31:0] d, input logic l, input logic r);
    MemAddr = a; WriteData = d; MemWrite = 1; MemRead = 0; WriteL = l; WriteR = r;
    step();
    proc_idle();
  endtask

  task automatic load_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
    MemAddr = a; MemRead = 1; MemWrite = 0;
    expect_data(tag, exp);
    step();
    proc_idle();
  endtask

  initial begin
    nReset = 0; InstrAddr = 0; MemAddr = 0; WriteData = 0;
    proc_idle();
    LoadValid = 0; LoadAddr = 0; LoadData = 0; LoadLast = 0;

    tick(); tick();
    check("rst_instr", InstrMem, 32'h0);
    check("rst_mdata", MemData, 32'h0);
    check("rst_ready", {31'h0, LoadReady}, 32'h0);
    check("rst_procn", {31'h0, ProcnReset}, 32'h0);
    check("rst_err", {31'h0, Err}, 32'h0);

    nReset = 1;
    tick();
    check("boot_ready", {31'h0, LoadReady}, 32'h1);
    check("boot_procn", {31'h0, ProcnReset}, 32'h0);

    // Processor traffic during BOOT must be ignored.
    MemRead = 1; MemWrite = 1; MemAddr = 16'h0000; WriteData = 32'hBADBAD00;
    for (int i = 0; i < 4; i++) begin
      LoadValid = 1;
      LoadAddr  = AW'(i);
      LoadData  = 32'h11111111 * (i + 1);
      LoadLast  = (i == 3);
      tick();
    end
    LoadValid = 0; LoadLast = 0;
    proc_idle();
    check("last_ready", {31'h0, LoadReady}, 32'h0);
    check("last_procn", {31'h0, ProcnReset}, 32'h0);
    check("boot_mdata", MemData, 32'h0);

    // Loader beat in RUN must not land.
    LoadValid = 1; LoadAddr = 1; LoadData = 32'hFFFFFFFF;
    tick();
    LoadValid = 0;
    check("run_procn", {31'h0, ProcnReset}, 32'h1);
    check("run_ready", {31'h0, LoadReady}, 32'h0);

    InstrAddr = 16'h0008; expect_instr("fetch_08", 32'h33333333); step();
    InstrAddr = 16'h000B; expect_instr("fetch_0B", 32'h33333333); step();
    InstrAddr = 16'h0004; expect_instr("fetch_ld_ignored", 32'h22222222); step();
    InstrAddr = 16'h1000; expect_instr("fetch_alias", 32'h11111111); step();
    load_check("boot_wr_ignored", 16'h0000, 32'h11111111);

    store(16'h0010, 32'hDEADBEEF, 0, 0);
    InstrAddr = 16'h0010; expect_instr("fetch_stored", 32'hDEADBEEF);
    load_check("word_store", 16'h0010, 32'hDEADBEEF);

    store(16'h0020, 32'h11223344, 0, 0);
    store(16'h0021, 32'hAABBCCDD, 1, 0);
    load_check("swl_lane1", 16'h0020, 32'h1122CCDD);
    store(16'h0022, 32'h99887766, 0, 1);
    load_check("swr_lane2", 16'h0020, 32'h9988CCDD);
    check("err_clear", {31'h0, Err}, 32'h0);
    store(16'h0020, 32'h00000000, 1, 1);
    check("err_set", {31'h0, Err}, 32'h1);
    load_check("both_no_write", 16'h0020, 32'h9988CCDD);
    store(16'h0027, 32'h01020304, 1, 0);
    load_check("swl_lane3_full", 16'h0024, 32'h01020304);
    store(16'h002C, 32'hCAFEF00D, 0, 1);
    load_check("swr_lane0_full", 16'h002C, 32'hCAFEF00D);

    store(16'h0030, 32'h00000000, 0, 0);
    MemAddr = 16'h0030; MemRead = 1; MemWrite = 1; WriteData = 32'h5;
    expect_data("read_first", 32'h0);
    step();
    proc_idle();
    load_check("after_rf", 16'h0030, 32'h5);
    load_check("alias_1030", 16'h1030, 32'h5);

    MemRead = 0; expect_data("mdata_hold", 32'h5); step();

    InstrAddr = 16'h0030; MemAddr = 16'h0030; MemWrite = 1; WriteData = 32'h7;
    expect_instr("fetch_prewrite", 32'h5);
    step();
    proc_idle();
    expect_instr("fetch_postwrite", 32'h7); step();
    check("err_sticky", {31'h0, Err}, 32'h1);

    #2 nReset = 0;
    #1;
    check("mid_procn", {31'h0, ProcnReset}, 32'h0);
    check("mid_mdata", MemData, 32'h0);
    check("mid_err", {31'h0, Err}, 32'h0);
    tick();
    nReset = 1;
    tick();
    check("mid_ready", {31'h0, LoadReady}, 32'h1);
    check("mid_procn_boot", {31'h0, ProcnReset}, 32'h0);

    LoadValid = 1; LoadLast = 1; LoadAddr = 15; LoadData = 32'h0F0F0F0F;
    tick();
    LoadValid = 0; LoadLast = 0;
    tick();
    check("reboot_procn", {31'h0, ProcnReset}, 32'h1);
    InstrAddr = 16'h0008; expect_instr("retained_fetch", 32'h33333333); step();
    load_check("retained_word", 16'h0010, 32'hDEADBEEF);
    load_check("reload_word", 16'h003C, 32'h0F0F0F0F);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
